nonogram_grid_editor: RTL and testbench

//  Player-side producer of the nonogram grid. Turns held push-button levels into cursor moves and

---
 rtl/nonogram_pkg.sv | 19 +
 rtl/nonogram_grid_editor_btn_repeat.sv | 56 +++++
 rtl/nonogram_grid_editor.sv | 152 +++++++++++++++
 tb/tb_nonogram_grid_editor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/nonogram_pkg.sv
// Shared grid defaults, editor state encoding and cell-to-bit mapping for the nonogram editor.
// Bit MSB is cell (0,0), the top-left corner; rows are packed top to bottom.
package nonogram_pkg;

  localparam int GRID_W_DEF = 10;
  localparam int GRID_H_DEF = 10;

  typedef enum logic [1:0] {
    ST_EDIT   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_LOCKED = 2'd2
  } editor_state_t;

  function automatic int cell_index(input int x, input int y,
                                    input int w = GRID_W_DEF, input int h = GRID_H_DEF);
    return (h - 1 - y) * w + (w - 1 - x);
  endfunction

endpackage

// File: rtl/nonogram_grid_editor_btn_repeat.sv
// Direction button conditioner: edge detect plus hold-delay/auto-repeat counter.
// Emits a one-cycle step pulse on the rise and at each repeat point while held.
module btn_repeat #(
  parameter int unsigned REPEAT_DLY  = 2500000,
  parameter int unsigned REPEAT_RATE = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic en,
  output logic step
);

  localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int CW = $clog2(CNT_MAX + 1);

  logic          btn_q;
  logic [CW-1:0] cnt;
  logic          rep;

  // cnt == 0 means disarmed: only a genuine rise while enabled arms the counter
  always_comb begin
    step = 1'b0;
    if (en && btn) begin
      if (!btn_q)
        step = 1'b1;
      else if (cnt != '0)
        step = rep ? (cnt == CW'(REPEAT_RATE)) : (cnt == CW'(REPEAT_DLY));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_q <= 1'b0;
      cnt   <= '0;
      rep   <= 1'b0;
    end else begin
      btn_q <= btn;
      if (!en || !btn) begin
        cnt <= '0;
        rep <= 1'b0;
      end else if (!btn_q) begin
        cnt <= CW'(1);
        rep <= 1'b0;
      end else if (cnt != '0) begin
        if (step) begin
          cnt <= CW'(1);
          rep <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/nonogram_grid_editor.sv
// Nonogram player grid editor: cursor moves, paint/block toggles and row-by-row clear sweep.
// Optional one-deep undo (btn_undo port) is built when NONOGRAM_UNDO_EN is defined.
module nonogram_grid_editor
  import nonogram_pkg::*;
#(
  parameter int          GRID_W      = GRID_W_DEF,
  parameter int          GRID_H      = GRID_H_DEF,
  parameter int unsigned REPEAT_DLY  = 2500000,
  parameter int unsigned REPEAT_RATE = 500000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     btn_up,
  input  logic                     btn_down,
  input  logic                     btn_left,
  input  logic                     btn_right,
  input  logic                     btn_paint,
  input  logic                     btn_block,
`ifdef NONOGRAM_UNDO_EN
  input  logic                     btn_undo,
`endif
  input  logic                     clear_req,
  input  logic                     lock,
  output logic [3:0]               sel_x,
  output logic [3:0]               sel_y,
  output logic [GRID_W*GRID_H-1:0] paint,
  output logic [GRID_W*GRID_H-1:0] block,
  output logic                     event_off
);

  editor_state_t state;
  logic [3:0]    clr_row;
  logic          paint_q, block_q;
  logic          mv_up, mv_down, mv_left, mv_right;
  logic          edit_en;
  int            cur_idx;

`ifdef NONOGRAM_UNDO_EN
  localparam int IDX_W = $clog2(GRID_W * GRID_H);
  logic             undo_q;
  logic             undo_valid;
  logic [IDX_W-1:0] undo_idx;
  logic             undo_p, undo_b;
`endif

  // Repeat counters only run while edits would actually be applied this cycle
  assign edit_en = (state == ST_EDIT) && !clear_req && !lock;
  assign cur_idx = cell_index(int'(sel_x), int'(sel_y), GRID_W, GRID_H);

  btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)) u_rep_up
    (.clk(clk), .rst_n(rst_n), .btn(btn_up),    .en(edit_en), .step(mv_up));
  btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)) u_rep_down
    (.clk(clk), .rst_n(rst_n), .btn(btn_down),  .en(edit_en), .step(mv_down));
  btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)) u_rep_left
    (.clk(clk), .rst_n(rst_n), .btn(btn_left),  .en(edit_en), .step(mv_left));
  btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)) u_rep_right
    (.clk(clk), .rst_n(rst_n), .btn(btn_right), .en(edit_en), .step(mv_right));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_EDIT;
      clr_row   <= '0;
      sel_x     <= '0;
      sel_y     <= '0;
      paint     <= '0;
      block     <= '0;
      event_off <= 1'b0;
      paint_q   <= 1'b0;
      block_q   <= 1'b0;
`ifdef NONOGRAM_UNDO_EN
      undo_q     <= 1'b0;
      undo_valid <= 1'b0;
      undo_idx   <= '0;
      undo_p     <= 1'b0;
      undo_b     <= 1'b0;
`endif
    end else begin
      paint_q <= btn_paint;
      block_q <= btn_block;
`ifdef NONOGRAM_UNDO_EN
      undo_q  <= btn_undo;
`endif
      if (clear_req) begin
        state     <= ST_CLEAR;
        clr_row   <= '0;
        sel_x     <= '0;
        sel_y     <= '0;
        event_off <= 1'b1;
`ifdef NONOGRAM_UNDO_EN
        undo_valid <= 1'b0;
`endif
      end else begin
        case (state)
          ST_CLEAR: begin
            for (int x = 0; x < GRID_W; x++) begin
              paint[cell_index(x, int'(clr_row), GRID_W, GRID_H)] <= 1'b0;
              block[cell_index(x, int'(clr_row), GRID_W, GRID_H)] <= 1'b0;
            end
            if (clr_row == 4'(GRID_H - 1)) begin
              state     <= lock ? ST_LOCKED : ST_EDIT;
              event_off <= lock;
            end else begin
              clr_row <= clr_row + 4'd1;
            end
          end
          ST_LOCKED: begin
            if (!lock) begin
              state     <= ST_EDIT;
              event_off <= 1'b0;
            end
          end
          default: begin
            if (lock) begin
              state     <= ST_LOCKED;
              event_off <= 1'b1;
            end else begin
              // Edit targets the pre-move cursor; paint beats block, both beat undo
              if (btn_paint && !paint_q) begin
                paint[cur_idx] <= !paint[cur_idx];
                block[cur_idx] <= 1'b0;
              end else if (btn_block && !block_q) begin
                block[cur_idx] <= !block[cur_idx];
                paint[cur_idx] <= 1'b0;
              end
`ifdef NONOGRAM_UNDO_EN
              if ((btn_paint && !paint_q) || (btn_block && !block_q)) begin
                undo_valid <= 1'b1;
                undo_idx   <= IDX_W'(cur_idx);
                undo_p     <= paint[cur_idx];
                undo_b     <= block[cur_idx];
              end else if (btn_undo && !undo_q && undo_valid) begin
                paint[undo_idx] <= undo_p;
                block[undo_idx] <= undo_b;
                undo_valid      <= 1'b0;
              end
`endif
              if (mv_up)
                sel_y <= (sel_y == '0) ? 4'(GRID_H - 1) : sel_y - 4'd1;
              else if (mv_down)
                sel_y <= (sel_y == 4'(GRID_H - 1)) ? '0 : sel_y + 4'd1;
              else if (mv_left)
                sel_x <= (sel_x == '0) ? 4'(GRID_W - 1) : sel_x - 4'd1;
              else if (mv_right)
                sel_x <= (sel_x == 4'(GRID_W - 1)) ? '0 : sel_x + 4'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nonogram_grid_editor.sv
// Scoreboard bench for nonogram_grid_editor: directed button sequences push expected cursor/grid
// snapshots; a negedge monitor pops and compares them against the DUT outputs.
module tb_nonogram_grid_editor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         bu, bd, bl, br, bp, bb;
  logic         clear_req, lock;
  logic [3:0]   sel_x, sel_y;
  logic [99:0]  paint, block;
  logic         event_off;
`ifdef NONOGRAM_UNDO_EN
  logic         bun;
`endif

  typedef struct {
    string       name;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [99:0] p;
    logic [99:0] b;
    logic        eo;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [99:0] ep, eb;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  nonogram_grid_editor #(.GRID_W(10), .GRID_H(10), .REPEAT_DLY(4), .REPEAT_RATE(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(bu), .btn_down(bd), .btn_left(bl), .btn_right(br),
    .btn_paint(bp), .btn_block(bb),
`ifdef NONOGRAM_UNDO_EN
    .btn_undo(bun),
`endif
    .clear_req(clear_req), .lock(lock),
    .sel_x(sel_x), .sel_y(sel_y), .paint(paint), .block(block), .event_off(event_off)
  );

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if ({sel_x, sel_y, event_off} !== {e.x, e.y, e.eo} || paint !== e.p || block !== e.b) begin
        n_err++;
        $display("FAIL %s: got x=%0d y=%0d eo=%b paint=%h block=%h ; want x=%0d y=%0d eo=%b paint=%h block=%h",
                 e.name, sel_x, sel_y, event_off, paint, block, e.x, e.y, e.eo, e.p, e.b);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input logic [3:0] x, input logic [3:0] y, input logic eo);
    sb.push_back('{n, x, y, ep, eb, eo});
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r,
                       input logic p, input logic b);
    bu = u; bd = d; bl = l; br = r; bp = p; bb = b;
    step();
    bu = 0; bd = 0; bl = 0; br = 0; bp = 0; bb = 0;
    step();
  endtask

`ifdef NONOGRAM_UNDO_EN
  task automatic press_undo();
    bun = 1'b1;
    step();
    bun = 1'b0;
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; bu = 0; bd = 0; bl = 0; br = 0; bp = 0; bb = 0;
    clear_req = 1'b0; lock = 1'b0;
`ifdef NONOGRAM_UNDO_EN
    bun = 1'b0;
`endif
    ep = '0; eb = '0;
    step(); step();
    push("reset", 0, 0, 0);
    rst_n = 1'b1;
    step();

    // Basic moves and wrap-around
    repeat (3) press(0, 0, 0, 1, 0, 0);
    push("right3", 3, 0, 0);
    repeat (3) press(0, 0, 1, 0, 0, 0);
    push("left_home", 0, 0, 0);
    press(0, 0, 1, 0, 0, 0);
    push("wrap_left", 9, 0, 0);
    press(1, 0, 0, 0, 0, 0);
    push("wrap_up", 9, 9, 0);
    press(1, 0, 1, 0, 0, 0);
    push("up_over_left", 9, 8, 0);

    // Paint/block toggles at (2,1) -> bit 87
    repeat (3) press(0, 0, 0, 1, 0, 0);
    repeat (3) press(0, 1, 0, 0, 0, 0);
    push("at_2_1", 2, 1, 0);
    press(0, 0, 0, 0, 1, 0);
    ep[87] = 1'b1;
    push("paint", 2, 1, 0);
    press(0, 0, 0, 0, 0, 1);
    ep[87] = 1'b0; eb[87] = 1'b1;
    push("block_over_paint", 2, 1, 0);
    press(0, 0, 0, 0, 0, 1);
    eb[87] = 1'b0;
    push("unblock", 2, 1, 0);
    press(0, 0, 0, 0, 1, 1);
    ep[87] = 1'b1;
    push("paint_wins", 2, 1, 0);
    press(0, 0, 0, 1, 1, 0);
    ep[87] = 1'b0;
    push("edit_then_move", 3, 1, 0);

    // Auto-repeat: moves on held cycles 1,5,7,9,11
    repeat (3) press(0, 0, 1, 0, 0, 0);
    press(1, 0, 0, 0, 0, 0);
    push("home", 0, 0, 0);
    br = 1'b1;
    step();
    push("hold_c1", 1, 0, 0);
    repeat (3) step();
    push("hold_c4", 1, 0, 0);
    step();
    push("hold_c5", 2, 0, 0);
    repeat (6) step();
    push("hold_c11", 5, 0, 0);
    br = 1'b0;
    step();
    push("hold_release", 5, 0, 0);

    // Clear sweep: paint (5,0)=bit94, block (6,0)=bit93
    press(0, 0, 0, 0, 1, 0);
    press(0, 0, 0, 1, 0, 0);
    press(0, 0, 0, 0, 0, 1);
    ep[94] = 1'b1; eb[93] = 1'b1;
    push("grid_dirty", 6, 0, 0);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    push("clear_entry", 0, 0, 1);
    br = 1'b1; bp = 1'b1;
    repeat (9) step();
    ep = '0; eb = '0;
    push("clear_c10", 0, 0, 1);
    step();
    push("clear_done", 0, 0, 0);
    repeat (6) step();
    push("held_no_fire", 0, 0, 0);
    br = 1'b0; bp = 1'b0;
    step();

    // Lock freezes editing
    lock = 1'b1;
    step();
    push("locked", 0, 0, 1);
    press(0, 0, 0, 1, 1, 0);
    push("locked_ignore", 0, 0, 1);
    lock = 1'b0;
    step();
    push("unlocked", 0, 0, 0);
    press(0, 0, 0, 1, 0, 0);
    push("move_after_unlock", 1, 0, 0);

`ifdef NONOGRAM_UNDO_EN
    // Undo at (5,5) -> bit 44
    repeat (4) press(0, 0, 0, 1, 0, 0);
    repeat (5) press(0, 1, 0, 0, 0, 0);
    press(0, 0, 0, 0, 1, 0);
    ep[44] = 1'b1;
    push("undo_paint", 5, 5, 0);
    press_undo();
    ep[44] = 1'b0;
    push("undo_restore", 5, 5, 0);
    press_undo();
    push("undo_empty", 5, 5, 0);
`endif

    for (int i = 0; i < 10 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
